// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I memory-access stage. Takes the ALU result as the
//            effective address and rs2 as store data, runs one load or store
//            against a word-wide data memory through a req/ready handshake,
//            and returns sign- or zero-extended load data for write-back.
//            busy stalls the CPU until the one-cycle done pulse.
// Ports    : clk, reset (async, active-low)
//            CPU side : start, is_store, funct3, addr, store_data
//                       -> busy, done, err, load_data
//            Mem side : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//                       <- mem_ready, mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic                 r_is_store;
  logic [2:0]           r_funct3;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_err;
  logic [31:0]          r_load_data;

  logic                 w_legal;
  logic                 w_aligned;
  logic                 w_ok;
  logic [31:0]          w_wdata;
  logic [3:0]           w_wstrb;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_timeout;
  logic [31:0]          w_byte_sh;
  logic [31:0]          w_half_sh;
  logic [31:0]          w_ext;

  // --------------------------------------------------------------------------
  // Request decode on the raw CPU inputs (only meaningful when start in IDLE)
  // --------------------------------------------------------------------------
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !is_store;
      default:                w_legal = 1'b0;
    endcase

    w_aligned = 1'b1;
    if (funct3[1:0] == 2'b01) begin
      w_aligned = !addr[0];
    end else if (funct3[1:0] == 2'b10) begin
      w_aligned = (addr[1:0] == 2'b00);
    end

    w_ok = w_legal && w_aligned;
  end

  // Store lane placement; loads present zero strobes and zero write data.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        2'b10: begin
          w_wstrb = 4'b1111;
          w_wdata = store_data;
        end
        default: begin
          w_wstrb = 4'b0000;
          w_wdata = 32'h0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction from the returned word using the latched byte offset
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte_sh = mem_rdata >> {r_addr[1:0], 3'b000};
    w_half_sh = mem_rdata >> {r_addr[1], 4'b0000};
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      3'b001:  w_ext = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      3'b010:  w_ext = mem_rdata;
      3'b100:  w_ext = {24'h0, w_byte_sh[7:0]};
      3'b101:  w_ext = {16'h0, w_half_sh[15:0]};
      default: w_ext = 32'h0;
    endcase
  end

  // Counter value after this REQ cycle; timeout fires on the cycle that
  // would bring it to TIMEOUT_CYCLES, giving exactly TIMEOUT_CYCLES REQ cycles.
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == C_TIMEOUT);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Illegal or misaligned requests skip memory entirely.
          w_state_next = w_ok ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (mem_ready || w_timeout) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, timeout counter, error flag and load result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'b0000;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_load_data <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_store <= is_store;
            r_funct3   <= funct3;
            r_addr     <= addr;
            r_wdata    <= w_wdata;
            r_wstrb    <= w_wstrb;
            r_cnt      <= '0;
            r_err      <= !w_ok;
            if (!w_ok) begin
              r_load_data <= 32'h0;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            r_err       <= 1'b0;
            r_load_data <= r_is_store ? 32'h0 : w_ext;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_load_data <= 32'h0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state so an async reset clears them immediately
  // --------------------------------------------------------------------------
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_RESP);
  assign err       = (r_state == S_RESP) && r_err;
  assign load_data = r_load_data;
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = mem_req && r_is_store;
  assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? r_wdata : 32'h0;
  assign mem_wstrb = mem_req ? r_wstrb : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. Expected write-back
//            results are queued when a request is issued and popped when the
//            done pulse appears. A negedge responder models memory wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .err(err), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t exp_v;

  // Memory responder: asserts mem_ready after ready_delay cycles of mem_req.
  int ready_delay = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready = (wcnt >= ready_delay);
      wcnt = wcnt + 1;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Observations from the most recent request.
  int          op_lat, op_req;
  bit          op_done;
  logic        op_we, op_err;
  logic [3:0]  op_wstrb;
  logic [31:0] op_maddr, op_wdata, op_ld, op_hold;

  // Issues one request and observes it until done (bounded), then idles a cycle.
  task automatic run_op(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    op_lat = 0; op_req = 0; op_done = 0; op_we = 0; op_err = 0;
    op_wstrb = 0; op_maddr = 0; op_wdata = 0; op_ld = 32'hx; op_hold = 32'hx;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (mem_req) begin
        op_req++;
        op_maddr = mem_addr; op_wdata = mem_wdata;
        op_wstrb = mem_wstrb; op_we = mem_we;
      end
      if (done) begin
        op_done = 1; op_lat = k; op_err = err; op_ld = load_data;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_hold = load_data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    total++;
    if ({busy, done, err, mem_req, mem_we} !== 5'b0 || load_data !== 32'h0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b req=%b we=%b ld=%h addr=%h wd=%h ws=%b want all zero",
               busy, done, err, mem_req, mem_we, load_data, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sw_lw();
    ready_delay = 0;
    sb_q.push_back('{err: 1'b0, data: 32'h0});
    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    exp_v = sb_q.pop_front();
    total++;
    if (op_lat !== 2 || op_req !== 1) begin
      bad++; $display("FAIL sw_timing: got lat=%0d req=%0d want lat=2 req=1", op_lat, op_req);
    end
    total++;
    if (op_wstrb !== 4'b1111 || op_maddr !== 32'h10 || op_wdata !== 32'hDEADBEEF || op_we !== 1'b1) begin
      bad++; $display("FAIL sw_bus: got ws=%b a=%h wd=%h we=%b want 1111 00000010 deadbeef 1",
                      op_wstrb, op_maddr, op_wdata, op_we);
    end
    total++;
    if (op_err !== exp_v.err || op_ld !== exp_v.data) begin
      bad++; $display("FAIL sw_result: got err=%b ld=%h want err=%b ld=%h", op_err, op_ld, exp_v.err, exp_v.data);
    end

    mem_rdata = 32'hDEADBEEF;
    sb_q.push_back('{err: 1'b0, data: 32'hDEADBEEF});
    run_op(1'b0, 3'b010, 32'h10, 32'h0);
    exp_v = sb_q.pop_front();
    total++;
    if (!op_done || op_err !== exp_v.err || op_ld !== exp_v.data || op_we !== 1'b0 || op_wstrb !== 4'b0) begin
      bad++; $display("FAIL lw_result: got done=%0d err=%b ld=%h we=%b ws=%b want err=%b ld=%h we=0 ws=0000",
                      op_done, op_err, op_ld, op_we, op_wstrb, exp_v.err, exp_v.data);
    end
    total++;
    if (op_hold !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_hold: got %h want deadbeef", op_hold);
    end
  endtask

  task automatic test_extract();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs[4] = '{32'h3, 32'h3, 32'h2, 32'h0};
    logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    mem_rdata = 32'h80FF7F01;
    ready_delay = 0;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{err: 1'b0, data: exps[i]});
      run_op(1'b0, f3s[i], adrs[i], 32'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (!op_done || op_err !== exp_v.err || op_ld !== exp_v.data || op_maddr !== {adrs[i][31:2], 2'b00}) begin
        bad++; $display("FAIL extract_%0d: got done=%0d err=%b ld=%h addr=%h want ld=%h",
                        i, op_done, op_err, op_ld, op_maddr, exp_v.data);
      end
    end
  endtask

  task automatic test_sb_sh();
    logic [2:0]  f3s [2] = '{3'b000, 3'b001};
    logic [31:0] dats[2] = '{32'h000000AB, 32'h00001234};
    logic [3:0]  ews [2] = '{4'b0100, 4'b1100};
    logic [31:0] ewd [2] = '{32'hABABABAB, 32'h12341234};
    ready_delay = 0;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{err: 1'b0, data: 32'h0});
      run_op(1'b1, f3s[i], 32'h22, dats[i]);
      exp_v = sb_q.pop_front();
      total++;
      if (op_maddr !== 32'h20 || op_wstrb !== ews[i] || op_wdata !== ewd[i] || op_we !== 1'b1) begin
        bad++; $display("FAIL store_lane_%0d: got a=%h ws=%b wd=%h we=%b want a=00000020 ws=%b wd=%h",
                        i, op_maddr, op_wstrb, op_wdata, op_we, ews[i], ewd[i]);
      end
      total++;
      if (!op_done || op_err !== exp_v.err || op_ld !== exp_v.data) begin
        bad++; $display("FAIL store_result_%0d: got err=%b ld=%h want err=0 ld=0", i, op_err, op_ld);
      end
    end
  endtask

  task automatic test_errors();
    logic        sts[3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s[3] = '{3'b010, 3'b011, 3'b011};
    logic [31:0] ads[3] = '{32'h6, 32'h10, 32'h10};
    ready_delay = 0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{err: 1'b1, data: 32'h0});
      run_op(sts[i], f3s[i], ads[i], 32'hFFFFFFFF);
      exp_v = sb_q.pop_front();
      total++;
      if (op_lat !== 1 || op_req !== 0 || op_err !== exp_v.err || op_ld !== exp_v.data) begin
        bad++; $display("FAIL error_%0d: got lat=%0d req=%0d err=%b ld=%h want lat=1 req=0 err=1 ld=0",
                        i, op_lat, op_req, op_err, op_ld);
      end
    end
  endtask

  task automatic test_wait_states();
    mem_rdata = 32'h13579BDF;
    ready_delay = 3;
    sb_q.push_back('{err: 1'b0, data: 32'h13579BDF});
    run_op(1'b0, 3'b010, 32'h40, 32'h0);
    exp_v = sb_q.pop_front();
    total++;
    if (op_req !== 4 || op_lat !== 5 || op_err !== exp_v.err || op_ld !== exp_v.data) begin
      bad++; $display("FAIL wait_states: got req=%0d lat=%0d err=%b ld=%h want req=4 lat=5 err=0 ld=%h",
                      op_req, op_lat, op_err, op_ld, exp_v.data);
    end
  endtask

  task automatic test_timeout();
    ready_delay = 1000;
    sb_q.push_back('{err: 1'b1, data: 32'h0});
    run_op(1'b0, 3'b010, 32'h44, 32'h0);
    exp_v = sb_q.pop_front();
    total++;
    if (op_req !== 16 || op_lat !== 17 || op_err !== exp_v.err || op_ld !== exp_v.data) begin
      bad++; $display("FAIL timeout: got req=%0d lat=%0d err=%b ld=%h want req=16 lat=17 err=1 ld=0",
                      op_req, op_lat, op_err, op_ld);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    ready_delay = 1000;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    total++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre: got req=%b busy=%b want 1 1", mem_req, busy);
    end
    reset = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid_async: got req=%b busy=%b done=%b want 0 0 0", mem_req, busy, done);
    end
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++;
    if (dones !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_nodone: got dones=%0d busy=%b want 0 0", dones, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int   dones = 0;
    logic [31:0] first_ld = 32'h0;
    mem_rdata = 32'h2468ACE0;
    ready_delay = 3;
    sb_q.push_back('{err: 1'b0, data: 32'h2468ACE0});
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h50;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h60; store_data = 32'h11111111;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (mem_req && mem_we) begin
        dones = dones + 100;
      end
      if (done) begin
        dones++;
        first_ld = load_data;
      end
      @(posedge clk); #1;
    end
    exp_v = sb_q.pop_front();
    total++;
    if (dones !== 1 || first_ld !== exp_v.data) begin
      bad++; $display("FAIL start_busy: got count=%0d ld=%h want count=1 ld=%h", dones, first_ld, exp_v.data);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_extract();
    test_sb_sh();
    test_errors();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_start_while_busy();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: got %0d entries want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RV32I CPU.
- Takes the ALU result as the effective address and rs2 as store data, and executes RV32I loads and stores against a word-wide data memory using a ready-based handshake.
- Returns sign- or zero-extended load data for register-file write-back.
- Holds busy so the CPU stalls PC update and write-back until done.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ waiting for mem_ready before aborting with err; 0 disables the timeout.
- CNT_WIDTH, 5: width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request pulse from CPU; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- funct3  in  3  RV32I load/store funct3; sampled with start.
- addr  in  32  effective address (ALU result); sampled with start.
- store_data  in  32  rs2 value; sampled with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned access, illegal funct3, or timeout.
- load_data  out  32  extended load result; valid with done; 0 for stores and on err.
- mem_req  out  1  memory request; held until mem_ready is seen.
- mem_we  out  1  write enable; valid while mem_req is high.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  replicated store data.
- mem_wstrb  out  4  byte strobes; 0000 for loads.
- mem_ready  in  1  memory accepted/completed the access this cycle.
- mem_rdata  in  32  read word; valid in the mem_ready cycle.

Behaviour:
- Reset (reset==0): state=IDLE. busy, done, err, mem_req, mem_we = 0; load_data, mem_addr, mem_wdata, mem_wstrb, timeout counter = 0. Takes effect immediately and asynchronously, including mid-request: mem_req drops without waiting for the clock and the pending access is discarded.
- States: IDLE, REQ, RESP.
  - IDLE → REQ: on a clk edge with start=1. Latch is_store, funct3, addr, store_data. Decode is legal and aligned.
  - IDLE → RESP: on a clk edge with start=1 when decode is illegal or misaligned. No memory access; err=1 in RESP.
  - REQ: mem_req=1, outputs stable. If mem_ready=1 at an edge: capture/extract mem_rdata and go to RESP. Otherwise the counter increments. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, go to RESP with err=1.
  - RESP: done=1 for exactly one cycle, then return to IDLE; counter clears.
- Latency with zero-wait memory (mem_ready high in the first REQ cycle): start edge → REQ (1 cycle) → RESP. done is asserted 2 cycles after the start edge.
- start asserted in REQ or RESP is ignored. It is not queued; the CPU must reissue it after done.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- Stores:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: wstrb = 0011 if addr[1]=0, else 1100; wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 1111; wdata = store_data.
- Loads:
  - Byte lane = mem_rdata >> (8*addr[1:0]); half lane = mem_rdata >> (16*addr[1]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- load_data holds its value until the next done pulse or reset.
- mem_addr, mem_we, mem_wdata, mem_wstrb drive 0 outside REQ.

Test Plan:
- SW then LW, zero-wait: SW addr=0x10, data=0xDEADBEEF → mem_wstrb=1111, mem_addr=0x10, done 2 cycles after start, err=0. Then LW addr=0x10 with mem_rdata=0xDEADBEEF → load_data=0xDEADBEEF.
- Byte/half extraction, mem_rdata=0x80FF7F01:
  - LB addr=3 → 0xFFFFFF80.
  - LBU addr=3 → 0x00000080.
  - LH addr=2 → 0xFFFF80FF.
  - LHU addr=0 → 0x00007F01.
- SB addr=0x22, data=0x000000AB → mem_addr=0x20, mem_wstrb=0100, mem_wdata=0xABABABAB. SH addr=0x22, data=0x1234 → mem_wstrb=1100, mem_wdata=0x12341234.
- Errors:
  - LW addr=0x6 → no mem_req; done at cycle 1 after start with err=1 and load_data=0.
  - funct3=011 → same response.
- Wait states and timeout:
  - mem_ready held low 3 cycles → mem_req high 4 cycles; done on the cycle after mem_ready.
  - mem_ready never asserted, TIMEOUT_CYCLES=16 → mem_req drops after 16 REQ cycles; done with err=1.
- Reset and start-while-busy:
  - Drive reset=0 during REQ → mem_req and busy fall immediately, with no done pulse.
  - start pulsed during REQ → ignored; exactly one done pulse.
